// File: rtl/lcd_transfer_gen.sv
// HD44780-style LCD bus transfer engine: one byte per request,
// 8-bit or two-nibble 4-bit bus timing, then a post-command wait.
module lcd_transfer_gen #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BUS_WIDTH = 4,
  parameter int SETUP_US  = 1,
  parameter int E_US      = 3,
  parameter int HOLD_US   = 1,
  parameter int GAP_US    = 1,
  parameter int DELAY_W   = 21
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 send,
  input  logic [7:0]           data,
  input  logic                 rs,
  input  logic                 single_nibble,
  input  logic [DELAY_W-1:0]   delay,
  output logic [BUS_WIDTH-1:0] LCD_D,
  output logic                 LCD_RS,
  output logic                 LCD_E,
  output logic                 busy,
  output logic                 done
);

  localparam int CYC_US = CLK_FREQ / 1000000;
  localparam int T_S = (SETUP_US * CYC_US > 1) ? SETUP_US * CYC_US : 1;
  localparam int T_E = (E_US * CYC_US > 1) ? E_US * CYC_US : 1;
  localparam int T_H = (HOLD_US * CYC_US > 1) ? HOLD_US * CYC_US : 1;
  localparam int T_G = (GAP_US * CYC_US > 1) ? GAP_US * CYC_US : 1;
  localparam int M1 = (T_S > T_E) ? T_S : T_E;
  localparam int M2 = (T_H > T_G) ? T_H : T_G;
  localparam int T_MAX = (M1 > M2) ? M1 : M2;
  localparam int TW = $clog2(T_MAX + 1);
  localparam int CW = (TW > DELAY_W) ? TW : DELAY_W;

  typedef enum logic [2:0] {
    IDLE, SETUP, EPULSE, HOLD, GAP, WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [7:0]           data_q, data_d;
  logic                 single_q, single_d;
  logic                 second_q, second_d;
  logic [DELAY_W-1:0]   delay_q, delay_d;
  logic [BUS_WIDTH-1:0] lcd_d_q, lcd_d_d;
  logic                 lcd_rs_q, lcd_rs_d;
  logic                 lcd_e_q, lcd_e_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [7:0] first8;
  logic [7:0] second8;
  logic       two_nib;
  logic       wait_end;

  // Low bits of these carry the bus value for either width.
  assign first8  = (BUS_WIDTH == 8) ? data : {4'h0, data[7:4]};
  assign second8 = (BUS_WIDTH == 8) ? data_q : {4'h0, data_q[3:0]};
  assign two_nib = (BUS_WIDTH == 4) && !single_q && !second_q;
  assign wait_end = cnt_q[DELAY_W-1:0] == (delay_q - DELAY_W'(1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    data_d   = data_q;
    single_d = single_q;
    second_d = second_q;
    delay_d  = delay_q;
    lcd_d_d  = lcd_d_q;
    lcd_rs_d = lcd_rs_q;
    lcd_e_d  = lcd_e_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (send) begin
          state_d  = SETUP;
          data_d   = data;
          single_d = single_nibble;
          delay_d  = delay;
          second_d = 1'b0;
          lcd_d_d  = first8[BUS_WIDTH-1:0];
          lcd_rs_d = rs;
          busy_d   = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == CW'(T_S - 1)) begin
          state_d = EPULSE;
          cnt_d   = '0;
          lcd_e_d = 1'b1;
        end
      end
      EPULSE: begin
        if (cnt_q == CW'(T_E - 1)) begin
          state_d = HOLD;
          cnt_d   = '0;
          lcd_e_d = 1'b0;
        end
      end
      HOLD: begin
        if (cnt_q == CW'(T_H - 1)) begin
          cnt_d   = '0;
          lcd_d_d = '0;
          if (two_nib) begin
            state_d = GAP;
          end else begin
            lcd_rs_d = 1'b0;
            // A zero delay skips WAIT entirely.
            if (delay_q == '0) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      GAP: begin
        if (cnt_q == CW'(T_G - 1)) begin
          state_d  = SETUP;
          cnt_d    = '0;
          second_d = 1'b1;
          lcd_d_d  = second8[BUS_WIDTH-1:0];
        end
      end
      WAIT: begin
        if (wait_end) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      single_q <= 1'b0;
      second_q <= 1'b0;
      delay_q  <= '0;
      lcd_d_q  <= '0;
      lcd_rs_q <= 1'b0;
      lcd_e_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      single_q <= single_d;
      second_q <= second_d;
      delay_q  <= delay_d;
      lcd_d_q  <= lcd_d_d;
      lcd_rs_q <= lcd_rs_d;
      lcd_e_q  <= lcd_e_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign LCD_D  = lcd_d_q;
  assign LCD_RS = lcd_rs_q;
  assign LCD_E  = lcd_e_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_lcd_transfer_gen.sv
// Bench for lcd_transfer_gen: three instances (8-bit, 4-bit, clamped
// timing) share stimulus and are checked against a waveform schedule.
module tb_lcd_transfer_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        send;
  logic [7:0]  data;
  logic        rs;
  logic        single;
  logic [20:0] delay;

  logic [7:0] d8;
  logic [3:0] d4;
  logic [7:0] d0;
  logic rs8, e8, busy8, done8;
  logic rs4, e4, busy4, done4;
  logic rs0, e0, busy0, done0;

  lcd_transfer_gen #(.CLK_FREQ(4000000), .BUS_WIDTH(8)) u8 (
    .CLK(clk), .RST(rst), .send(send), .data(data), .rs(rs),
    .single_nibble(single), .delay(delay), .LCD_D(d8),
    .LCD_RS(rs8), .LCD_E(e8), .busy(busy8), .done(done8));

  lcd_transfer_gen #(.CLK_FREQ(4000000), .BUS_WIDTH(4)) u4 (
    .CLK(clk), .RST(rst), .send(send), .data(data), .rs(rs),
    .single_nibble(single), .delay(delay), .LCD_D(d4),
    .LCD_RS(rs4), .LCD_E(e4), .busy(busy4), .done(done4));

  lcd_transfer_gen #(.CLK_FREQ(500000), .BUS_WIDTH(8)) u0 (
    .CLK(clk), .RST(rst), .send(send), .data(data), .rs(rs),
    .single_nibble(single), .delay(delay), .LCD_D(d0),
    .LCD_RS(rs0), .LCD_E(e0), .busy(busy0), .done(done0));

  typedef struct packed {
    logic [7:0] d;
    logic       rs;
    logic       e;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    logic       single;
    int         delay;
    int         l8;
    int         l4;
    int         l0;
  } vec_t;

  localparam int FREQ [3] = '{4000000, 4000000, 500000};
  localparam int BW   [3] = '{8, 4, 8};

  exp_t q [3][$];
  exp_t expv [3];
  exp_t act [3];

  assign act[0] = {d8, rs8, e8, busy8, done8};
  assign act[1] = {4'h0, d4, rs4, e4, busy4, done4};
  assign act[2] = {d0, rs0, e0, busy0, done0};

  int pass_n = 0;
  int total_n = 0;
  int ecnt = 0;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic check(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
    total_n++;
    if (a === e) pass_n++;
    else $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h",
                  nm, ecnt, a, e);
  endtask

  function automatic int tcyc(input int us, input int f);
    int t;
    t = us * (f / 1000000);
    return (t > 1) ? t : 1;
  endfunction

  function automatic exp_t mk(input logic [7:0] dv, input logic r,
                              input logic e, input logic b,
                              input logic dn);
    return {dv, r, e, b, dn};
  endfunction

  // Expected per-cycle bus values of one accepted transfer.
  task automatic build(input int i);
    int nn;
    logic [7:0] dv;
    nn = (BW[i] == 4 && !single) ? 2 : 1;
    for (int n = 0; n < nn; n++) begin
      if (BW[i] == 8) dv = data;
      else if (n == 0) dv = {4'h0, data[7:4]};
      else dv = {4'h0, data[3:0]};
      for (int k = 0; k < tcyc(1, FREQ[i]); k++)
        q[i].push_back(mk(dv, rs, 1'b0, 1'b1, 1'b0));
      for (int k = 0; k < tcyc(3, FREQ[i]); k++)
        q[i].push_back(mk(dv, rs, 1'b1, 1'b1, 1'b0));
      for (int k = 0; k < tcyc(1, FREQ[i]); k++)
        q[i].push_back(mk(dv, rs, 1'b0, 1'b1, 1'b0));
      if (n == 0 && nn == 2)
        for (int k = 0; k < tcyc(1, FREQ[i]); k++)
          q[i].push_back(mk(8'h00, rs, 1'b0, 1'b1, 1'b0));
    end
    for (int k = 0; k < int'(delay); k++)
      q[i].push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
    q[i].push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  always begin
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        q[i].delete();
        expv[i] = '0;
      end else begin
        if (q[i].size() == 0 && send) build(i);
        expv[i] = (q[i].size() > 0) ? q[i].pop_front() : '0;
      end
    end
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("bus inst%0d", i), 32'(act[i]), 32'(expv[i]));
  end

  task automatic xfer(input vec_t v);
    int t0;
    int lat [3];
    logic [2:0] seen;
    @(negedge clk);
    send = 1'b1; data = v.data; rs = v.rs;
    single = v.single; delay = 21'(v.delay);
    t0 = ecnt;
    @(negedge clk);
    send = 1'b0; data = 8'($urandom); rs = 1'($urandom);
    single = 1'($urandom); delay = 21'($urandom % 8);
    seen = '0;
    lat = '{-1, -1, -1};
    for (int c = 0; c < 200 && seen != 3'b111; c++) begin
      @(posedge clk);
      #2;
      if (done8 && !seen[0]) begin seen[0] = 1'b1; lat[0] = ecnt - t0; end
      if (done4 && !seen[1]) begin seen[1] = 1'b1; lat[1] = ecnt - t0; end
      if (done0 && !seen[2]) begin seen[2] = 1'b1; lat[2] = ecnt - t0; end
    end
    check("done edge 8bit", lat[0], v.l8);
    check("done edge 4bit", lat[1], v.l4);
    check("done edge clamp", lat[2], v.l0);
    repeat (2) @(negedge clk);
  endtask

  vec_t tbl [6];
  int   nd;

  initial begin
    rst = 1'b1; send = 1'b0; data = '0; rs = 1'b0;
    single = 1'b0; delay = '0;
    tbl[0] = '{8'h38, 1'b0, 1'b0, 10, 31, 55, 14};
    tbl[1] = '{8'hA5, 1'b1, 1'b0, 0, 21, 45, 4};
    tbl[2] = '{8'h30, 1'b0, 1'b1, 0, 21, 21, 4};
    tbl[3] = '{8'h38, 1'b0, 1'b0, 3, 24, 48, 7};
    tbl[4] = '{8'h5A, 1'b1, 1'b1, 7, 28, 28, 11};
    tbl[5] = '{8'hC3, 1'b0, 1'b0, 1, 22, 46, 5};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset busy", busy8, 1'b0);
    check("reset lcd_d", d8, 8'h00);
    @(negedge clk);

    for (int k = 0; k < 6; k++) xfer(tbl[k]);

    // send during EPULSE is ignored
    @(negedge clk);
    send = 1'b1; data = 8'h38; rs = 1'b0; single = 1'b0; delay = 21'd2;
    @(negedge clk);
    send = 1'b0;
    repeat (6) @(negedge clk);
    send = 1'b1; data = 8'hFF;
    @(negedge clk);
    send = 1'b0;
    check("busy send e", e8, 1'b1);
    check("busy send d", d8, 8'h38);
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2;
      if (done8) nd++;
    end
    check("single done", nd, 1);

    // send held through the done cycle
    @(negedge clk);
    send = 1'b1; data = 8'h01; rs = 1'b1; delay = 21'd0;
    nd = 0;
    for (int c = 0; c < 100 && !done8; c++) begin
      @(posedge clk); #2;
    end
    check("b2b done", done8, 1'b1);
    check("b2b done busy", busy8, 1'b0);
    @(posedge clk); #2;
    check("b2b busy", busy8, 1'b1);
    check("b2b lcd_d", d8, 8'h01);
    @(negedge clk);
    send = 1'b0;
    repeat (80) @(negedge clk);

    // reset in EPULSE aborts the transfer
    send = 1'b1; data = 8'h38; rs = 1'b1; single = 1'b0; delay = 21'd5;
    @(negedge clk);
    send = 1'b0;
    repeat (7) @(negedge clk);
    check("pre-rst e", e8, 1'b1);
    rst = 1'b1;
    @(posedge clk); #2;
    check("rst e", e8, 1'b0);
    check("rst d", d8, 8'h00);
    check("rst rs", rs8, 1'b0);
    check("rst busy", busy8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #2;
      if (done8 || done4 || done0) nd++;
    end
    check("no done after rst", nd, 0);
    xfer(tbl[0]);

    // random traffic against the schedule model
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      send = ($urandom % 4) == 0;
      data = 8'($urandom);
      rs = 1'($urandom);
      single = 1'($urandom);
      delay = 21'($urandom % 12);
      rst = ($urandom % 200) == 0;
    end
    @(negedge clk);
    rst = 1'b0; send = 1'b0;
    repeat (100) @(negedge clk);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/lcd_transfer_gen.md
Name: lcd_transfer_gen

Overview:
Parametrised HD44780-style LCD bus transfer engine and successor to the fixed 5-bit nibble sender.
- Accepts one 8-bit command/data byte per request, with an RS flag and a post-command delay.
- Drives the LCD bus in 8-bit mode, or in 4-bit mode as two nibbles (high first), with programmable setup, E-pulse, hold and inter-nibble timing.
- Sits between the LCD init/print sequencer and the LCD pins.

Parameters:
CLK_FREQ, 50000000, CLK frequency in Hz; CYC_US = CLK_FREQ/1000000 (integer division).
BUS_WIDTH, 4, LCD data bus width; legal values 4 or 8 only.
SETUP_US, 1, data/RS setup before E rises; T_S = max(1, SETUP_US*CYC_US) cycles.
E_US, 3, E high time; T_E = max(1, E_US*CYC_US) cycles.
HOLD_US, 1, data hold after E falls; T_H = max(1, HOLD_US*CYC_US) cycles.
GAP_US, 1, idle gap between nibbles (4-bit mode); T_G = max(1, GAP_US*CYC_US) cycles.
DELAY_W, 21, width of the per-command delay input.

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
send  in  1  request strobe; sampled only when busy=0
data  in  8  byte to transfer
rs  in  1  register select for this transfer
single_nibble  in  1  4-bit mode only: send data[7:4] only (init sequence); ignored when BUS_WIDTH=8
delay  in  DELAY_W  post-transfer wait in CLK cycles
LCD_D  out  BUS_WIDTH  LCD data bus
LCD_RS  out  1  LCD register select
LCD_E  out  1  LCD enable strobe
busy  out  1  transfer in progress
done  out  1  one-cycle pulse when the transfer and its delay complete

Behaviour:
- One clock: CLK. RST is synchronous and active-high.
- Reset: state IDLE; LCD_D=0, LCD_RS=0, LCD_E=0, busy=0, done=0; all counters cleared. A reset mid-transfer aborts it: LCD_E is low after that edge, and no done pulse is produced.
- All outputs are registered.
- States: IDLE, SETUP, EPULSE, HOLD, GAP, WAIT.
- One phase counter, wide enough for max(T_S, T_E, T_H, T_G, 2^DELAY_W-1). It is cleared on every state entry.
- IDLE, send=1 at edge 0:
  - data, rs, single_nibble and delay are latched.
  - At edge 1: state SETUP, busy=1, LCD_RS=rs.
  - LCD_D = data (8-bit mode) or data[7:4] (4-bit mode).
- SETUP lasts T_S cycles, then EPULSE with LCD_E=1 at edge 1+T_S.
- EPULSE lasts T_E cycles. LCD_E=0 at the entry to HOLD.
- HOLD lasts T_H cycles. On exit, LCD_D=0.
- On leaving HOLD:
  - If a second nibble is pending (4-bit mode, single_nibble=0, first nibble just sent): go to GAP.
  - Otherwise: go to WAIT.
- GAP lasts T_G cycles. Then SETUP with LCD_D = data[3:0]; the second nibble uses the same SETUP/EPULSE/HOLD timing.
- LCD_RS holds the latched rs from SETUP entry until WAIT entry, then returns to 0.
- WAIT lasts delay cycles (delay=0 means zero cycles). done=1 and busy=0 at the same edge that returns to IDLE.
- Single-phase done edge: 1+T_S+T_E+T_H+delay.
- Two-nibble done edge: 1+2*(T_S+T_E+T_H)+T_G+delay.
- send while busy=1: ignored, with no queueing. Input changes while busy have no effect (latched copies are used).
- send=1 in the done cycle (busy=0, state IDLE): accepted, giving back-to-back transfers with no dead cycle.
- done never asserts without a preceding accepted send.
- LCD_E is high only in EPULSE.
- Delay counter compare is equality on DELAY_W-bit values. The counter never wraps, because WAIT exits on the match.

Test Plan:
1. CLK_FREQ=4000000, BUS_WIDTH=8 (T_S=4, T_E=12, T_H=4); send data=0x38, rs=0, delay=10 -> LCD_D=0x38 from edge 1, LCD_E high edges 5..16, LCD_D=0 at edge 21, done pulse at edge 31, busy high edges 1..30.
2. BUS_WIDTH=4, same timing, T_G=4; send data=0xA5, rs=1, delay=0 -> LCD_D=0xA from edge 1, E high 5..16; LCD_D=0x5 from edge 25, E high 29..40; LCD_RS=1 edges 1..44; done at edge 45.
3. BUS_WIDTH=4, single_nibble=1, data=0x30, delay=0 -> only nibble 0x3 is sent, exactly one E pulse, done at edge 21.
4. send pulsed during EPULSE with data=0xFF -> ignored: LCD_D keeps the original byte, and exactly one done is produced. Then send held high through the done cycle with data=0x01 -> second transfer starts the edge after done, LCD_D=0x01 (8-bit mode).
5. RST asserted at edge 8 (LCD_E=1) -> at edge 9: LCD_E=0, LCD_D=0, LCD_RS=0, busy=0; no done pulse; a fresh send then completes with normal timing.
6. CLK_FREQ=500000 (CYC_US=0) -> all phases clamp to 1 cycle; 8-bit transfer with delay=3 gives done at edge 7.
